pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage pipeline. Drives write-enable/flush of PC, IF/ID, ID/EX,
//  EX/MEM and MEM/WB registers. Handles the post-reset hold, load-use stalls, EX-resolved redirects and
//  data-memory wait states. Keeps stall/flush performance counters and a sticky memory-timeout error.
// PARAMETERS
//  RESET_HOLD   2     cycles the pipeline stays frozen and flushed after reset release (>=1)
//  MEM_TIMEOUT  255   max consecutive mem_busy_i cycles before err_timeout_o sets (>=1)
//  CNT_W        32    width of performance counters
// PORTS
//  clk_i            in   1      clock, rising edge
//  rst_ni           in   1      asynchronous, active-low reset
//  id_rs1_i         in   5      source reg 1 of instruction in ID
//  id_rs2_i         in   5      source reg 2 of instruction in ID
//  id_rs1_re_i      in   1      ID instruction reads rs1
//  id_rs2_re_i      in   1      ID instruction reads rs2
//  ex_rd_i          in   5      destination reg of instruction in EX
//  ex_mem_read_i    in   1      EX instruction is a load
//  ex_redirect_i    in   1      taken branch/jump resolved in EX (target muxed outside)
//  mem_busy_i       in   1      data memory not ready; MEM stage must hold
//  pc_we_o          out  1      PC update enable
//  if_id_we_o       out  1      IF/ID enable;   if_id_flush_o  out 1  IF/ID -> bubble
//  id_ex_we_o       out  1      ID/EX enable;   id_ex_flush_o  out 1  ID/EX -> bubble
//  ex_mem_we_o      out  1      EX/MEM enable;  mem_wb_flush_o out 1  MEM/WB -> bubble
//  state_o          out  2      FSM state (debug)
//  stall_cnt_o      out  CNT_W  cycles with pc_we_o=0 since reset
//  flush_cnt_o      out  CNT_W  redirect flushes since reset
//  err_timeout_o    out  1      sticky: mem_busy_i held > MEM_TIMEOUT cycles
// BEHAVIOUR
//  Reset (rst_ni=0, async): state=HOLD, hold_cnt=RESET_HOLD-1, busy_cnt=0, counters=0, err_timeout_o=0.
//  Control outputs are combinational from state and inputs (same-cycle effect); all state/counters registered.
//  States: HOLD=0, RUN=1, MEM_WAIT=2.
//  HOLD: all *_we_o=0, all *_flush_o=1. hold_cnt decrements each cycle; at 0 -> RUN. Inputs ignored.
//  RUN, priority high->low:
//   1 mem_busy_i=1: all *_we_o=0, mem_wb_flush_o=1, other flushes 0; next MEM_WAIT, busy_cnt=1.
//   2 ex_redirect_i=1: all we=1, if_id_flush_o=1, id_ex_flush_o=1; flush_cnt++.
//   3 load-use: ex_mem_read_i && ex_rd_i!=0 && ((id_rs1_re_i && id_rs1_i==ex_rd_i) ||
//     (id_rs2_re_i && id_rs2_i==ex_rd_i)): pc_we_o=0, if_id_we_o=0, id_ex_flush_o=1, EX/MEM
//     and later advance. Exactly one bubble; no FSM state needed (load leaves EX next cycle).
//   4 otherwise: all we=1, all flushes 0.
//  MEM_WAIT: while mem_busy_i=1 same outputs as RUN case 1; busy_cnt saturates at MEM_TIMEOUT+1;
//   err_timeout_o sets when busy_cnt reaches MEM_TIMEOUT+1 (sticky until reset). mem_busy_i=0: outputs
//   evaluated as RUN cases 2-4 (held redirect/load-use honoured that cycle), next RUN, busy_cnt=0.
//  Redirect and load-use in same cycle: redirect wins (stalled ID instruction is flushed anyway).
//  ex_rd_i=0 never creates a hazard. x0 writes never forwarded/stalled.
//  stall_cnt_o increments every cycle pc_we_o=0 incl. HOLD; both counters wrap modulo 2^CNT_W.
//  rst_ni assertion mid-stall/mid-wait aborts immediately to reset values; no pending event survives.
// STRUCTURE
//  pipe_ctrl_pkg: state enum (HOLD/RUN/MEM_WAIT), REG_X0=5'd0, default CNT_W.
//  Sub-module hazard_detect: combinational load-use compare (rs1/rs2/re/ex_rd/mem_read -> load_use).
//  Top holds FSM, hold/busy counters, perf counters, output priority mux.
// TESTING
//  T1 reset release, RESET_HOLD=2 -> 2 cycles all we=0/flush=1, state=RUN cycle 3, stall_cnt_o=2.
//  T2 ex_mem_read=1, ex_rd=5, id_rs1=5, rs1_re=1 -> pc_we=0, if_id_we=0, id_ex_flush=1 one cycle;
//     same with ex_rd=0 -> no stall.
//  T3 ex_redirect=1 together with load-use match -> pc_we=1, if_id_flush=1, id_ex_flush=1, flush_cnt+1.
//  T4 mem_busy=1 for 3 cycles with redirect held -> 3 cycles all we=0, mem_wb_flush=1, state=MEM_WAIT;
//     4th cycle redirect flush issued, state=RUN, stall_cnt_o +3.
//  T5 MEM_TIMEOUT=4, mem_busy=1 for 6 cycles -> err_timeout_o rises after 5th busy cycle, stays 1 after
//     busy drops; clears only on rst_ni=0.
//  T6 rst_ni=0 asynchronously during MEM_WAIT -> outputs at reset values before next clock edge.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the 5-stage pipeline hazard/sequencing
// controller.
//   state_e    : controller FSM state (encoding is visible on state_o)
//   REG_X0     : architectural zero register, never a hazard source
//   CNT_W_DEF  : default width of the performance counters
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0    = 5'd0;
  localparam int         CNT_W_DEF = 32;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundle between the pipeline datapath and its hazard controller.
//   Hazard inputs (datapath -> controller):
//     id_rs1, id_rs2, id_rs1_re, id_rs2_re : ID-stage source operands
//     ex_rd, ex_mem_read, ex_redirect       : EX-stage destination / load / taken branch
//     mem_busy                              : data memory wait request
//   Control outputs (controller -> datapath):
//     pc_we, if_id_we, id_ex_we, ex_mem_we  : register enables
//     if_id_flush, id_ex_flush, mem_wb_flush: bubble insertion
// master = datapath side, slave = controller side.
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_re;
  logic       id_rs2_re;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_redirect;
  logic       mem_busy;

  logic       pc_we;
  logic       if_id_we;
  logic       if_id_flush;
  logic       id_ex_we;
  logic       id_ex_flush;
  logic       ex_mem_we;
  logic       mem_wb_flush;

  modport master (
    output id_rs1, id_rs2, id_rs1_re, id_rs2_re, ex_rd, ex_mem_read, ex_redirect, mem_busy,
    input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_re, id_rs2_re, ex_rd, ex_mem_read, ex_redirect, mem_busy,
    output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use detector: the instruction in ID reads a register that
// the load currently in EX will write. x0 is never a hazard.
//   id_rs1_i, id_rs2_i       in  5 : ID source registers
//   id_rs1_re_i, id_rs2_re_i in  1 : ID actually reads rs1 / rs2
//   ex_rd_i                  in  5 : EX destination register
//   ex_mem_read_i            in  1 : EX instruction is a load
//   load_use_o               out 1 : one-cycle stall required
// -----------------------------------------------------------------------------
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_re_i,
  input  logic       id_rs2_re_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_rs1_re_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_rs2_re_i && (id_rs2_i == ex_rd_i);
  assign load_use_o = ex_mem_read_i && (ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and sequencing controller for the 5-stage pipeline. Freezes and
// flushes the pipe for RESET_HOLD cycles after reset, inserts load-use
// bubbles, flushes IF/ID and ID/EX on EX-resolved redirects and holds the
// whole pipe while data memory is busy. Control outputs are combinational
// from the registered state and the current inputs.
//   clk_i          in  1     : clock, rising edge
//   rst_ni         in  1     : asynchronous active-low reset
//   ctrl_if        slave     : hazard inputs / register enables and flushes
//   state_o        out 2     : FSM state (debug)
//   stall_cnt_o    out CNT_W : cycles with pc_we=0 since reset (wraps)
//   flush_cnt_o    out CNT_W : redirect flushes since reset (wraps)
//   err_timeout_o  out 1     : sticky, mem_busy held more than MEM_TIMEOUT cycles
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int RESET_HOLD  = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  pipeline_ctrl_if.slave   ctrl_if,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_timeout_o
);

  localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int                BUSY_W    = $clog2(MEM_TIMEOUT + 2);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
  localparam logic [BUSY_W-1:0] BUSY_SAT  = BUSY_W'(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q,  hold_d;
  logic [BUSY_W-1:0]  busy_q,  busy_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;
  logic               err_q,   err_d;

  logic load_use;
  logic redirect_taken;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic if_id_flush, id_ex_flush, mem_wb_flush;

  hazard_detect u_hazard_detect (
    .id_rs1_i      (ctrl_if.id_rs1),
    .id_rs2_i      (ctrl_if.id_rs2),
    .id_rs1_re_i   (ctrl_if.id_rs1_re),
    .id_rs2_re_i   (ctrl_if.id_rs2_re),
    .ex_rd_i       (ctrl_if.ex_rd),
    .ex_mem_read_i (ctrl_if.ex_mem_read),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    busy_d         = busy_q;
    redirect_taken = 1'b0;
    pc_we          = 1'b0;
    if_id_we       = 1'b0;
    id_ex_we       = 1'b0;
    ex_mem_we      = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    mem_wb_flush   = 1'b0;

    case (state_q)
      ST_HOLD: begin
        // Frozen and flushed; hazard inputs are not trustworthy yet.
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        mem_wb_flush = 1'b1;
        if (hold_q == '0) state_d = ST_RUN;
        else              hold_d  = hold_q - HOLD_W'(1);
      end

      ST_RUN, ST_MEM_WAIT: begin
        if (ctrl_if.mem_busy) begin
          // Whole pipe holds; MEM/WB gets a bubble so WB does not repeat.
          mem_wb_flush = 1'b1;
          state_d      = ST_MEM_WAIT;
          if (state_q == ST_RUN)      busy_d = BUSY_W'(1);
          else if (busy_q != BUSY_SAT) busy_d = busy_q + BUSY_W'(1);
        end else begin
          // A redirect or load-use that waited behind the memory stall is
          // honoured in the release cycle.
          state_d = ST_RUN;
          busy_d  = '0;
          if (ctrl_if.ex_redirect) begin
            // Wins over load-use: the stalled ID instruction is wrong-path.
            pc_we          = 1'b1;
            if_id_we       = 1'b1;
            id_ex_we       = 1'b1;
            ex_mem_we      = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            redirect_taken = 1'b1;
          end else if (load_use) begin
            // Single bubble: the load leaves EX next cycle, so no state kept.
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
          end
        end
      end

      default: begin
        // Unused encoding: recover through a fresh hold sequence.
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        mem_wb_flush = 1'b1;
        state_d      = ST_HOLD;
        hold_d       = HOLD_INIT;
        busy_d       = '0;
      end
    endcase

    stall_d = stall_q + CNT_W'(!pc_we);
    flush_d = flush_q + CNT_W'(redirect_taken);
    err_d   = err_q | (busy_d == BUSY_SAT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_HOLD;
      hold_q  <= HOLD_INIT;
      busy_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  assign ctrl_if.pc_we        = pc_we;
  assign ctrl_if.if_id_we     = if_id_we;
  assign ctrl_if.id_ex_we     = id_ex_we;
  assign ctrl_if.ex_mem_we    = ex_mem_we;
  assign ctrl_if.if_id_flush  = if_id_flush;
  assign ctrl_if.id_ex_flush  = id_ex_flush;
  assign ctrl_if.mem_wb_flush = mem_wb_flush;

  assign state_o       = state_q;
  assign stall_cnt_o   = stall_q;
  assign flush_cnt_o   = flush_q;
  assign err_timeout_o = err_q;

endmodule
